// File: rtl/axi_axil_burst_bridge_rd.sv
// AXI4 read slave to AXI4-Lite read master bridge.
// Each AXI burst beat becomes one AXI-Lite read, and each read returns one R beat.
module axi_axil_burst_bridge_rd #(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH    = 8,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXI_ID_WIDTH-1:0]    s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic [2:0]                 s_axi_arprot,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]    s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [ADDR_WIDTH-1:0]      m_axil_araddr,
  output logic [2:0]                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_WF_R = 3'd2;
  localparam logic [2:0] ST_R    = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int AXI_OFF  = $clog2(AXI_STRB_WIDTH);
  localparam int AXIL_OFF = $clog2(AXIL_STRB_WIDTH);
  localparam int MIN_STRB = (AXI_STRB_WIDTH < AXIL_STRB_WIDTH) ? AXI_STRB_WIDTH : AXIL_STRB_WIDTH;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(MIN_STRB));

  logic [2:0]                state_q, state_d;
  logic                      arready_q, arready_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [2:0]                wrap_lg_q, wrap_lg_d;
  logic [2:0]                prot_q, prot_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  logic [AXI_DATA_WIDTH-1:0] lane_data;
  logic [ADDR_WIDTH-1:0]     step, wrap_mask, next_addr;
  logic [2:0]                ar_wrap_lg;
  logic                      ar_invalid;

  // Place the AXI-Lite word on the AXI byte lanes selected by the current beat address.
  generate
    if (AXI_DATA_WIDTH > AXIL_DATA_WIDTH) begin : g_upsize
      localparam int AXIL_LG = $clog2(AXIL_DATA_WIDTH);
      logic [AXI_OFF-AXIL_OFF-1:0] lane_sel;
      assign lane_sel  = addr_q[AXI_OFF-1:AXIL_OFF];
      assign lane_data = {{(AXI_DATA_WIDTH-AXIL_DATA_WIDTH){1'b0}}, m_axil_rdata}
                         << {lane_sel, {AXIL_LG{1'b0}}};
    end else if (AXI_DATA_WIDTH < AXIL_DATA_WIDTH) begin : g_downsize
      localparam int AXI_LG = $clog2(AXI_DATA_WIDTH);
      logic [AXIL_OFF-AXI_OFF-1:0] lane_sel;
      assign lane_sel  = addr_q[AXIL_OFF-1:AXI_OFF];
      assign lane_data = m_axil_rdata[{lane_sel, {AXI_LG{1'b0}}} +: AXI_DATA_WIDTH];
    end else begin : g_passthru
      assign lane_data = m_axil_rdata;
    end
  endgenerate

  // WRAP lengths are powers of two, so the wrap boundary is a shift of the step.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = (step << wrap_lg_q) - ADDR_WIDTH'(1);
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:     next_addr = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
    endcase
  end

  always_comb begin
    case (s_axi_arlen)
      8'd1:    ar_wrap_lg = 3'd1;
      8'd3:    ar_wrap_lg = 3'd2;
      8'd7:    ar_wrap_lg = 3'd3;
      8'd15:   ar_wrap_lg = 3'd4;
      default: ar_wrap_lg = 3'd0;
    endcase
    ar_invalid = (s_axi_arburst == 2'b11) || (s_axi_arsize > MAX_SIZE) ||
                 ((s_axi_arburst == BURST_WRAP) && (ar_wrap_lg == 3'd0));
  end

  always_comb begin
    state_d    = state_q;
    arready_d  = 1'b1;
    id_d       = id_q;
    addr_d     = addr_q;
    size_d     = size_q;
    burst_d    = burst_q;
    wrap_lg_d  = wrap_lg_q;
    prot_d     = prot_q;
    beat_cnt_d = beat_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axi_arvalid && s_axi_arready) begin
          id_d       = s_axi_arid;
          addr_d     = s_axi_araddr;
          size_d     = s_axi_arsize;
          burst_d    = s_axi_arburst;
          wrap_lg_d  = ar_wrap_lg;
          prot_d     = s_axi_arprot;
          beat_cnt_d = s_axi_arlen;
          if (ar_invalid) begin
            state_d = ST_ERR;
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (m_axil_arready) state_d = ST_WF_R;
      end
      ST_WF_R: begin
        if (m_axil_rvalid) begin
          rdata_d = lane_data;
          rresp_d = m_axil_rresp;
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (s_axi_rready) begin
          if (beat_cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
            addr_d     = next_addr;
            state_d    = ST_AR;
          end
        end
      end
      ST_ERR: begin
        if (s_axi_rready) begin
          if (beat_cnt_q == 8'd0) state_d = ST_IDLE;
          else beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      arready_q  <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      wrap_lg_q  <= '0;
      prot_q     <= '0;
      beat_cnt_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      wrap_lg_q  <= wrap_lg_d;
      prot_q     <= prot_d;
      beat_cnt_q <= beat_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi_arready  = arready_q && (state_q == ST_IDLE);
  assign s_axi_rvalid   = (state_q == ST_R) || (state_q == ST_ERR);
  assign s_axi_rlast    = s_axi_rvalid && (beat_cnt_q == 8'd0);
  assign s_axi_rid      = id_q;
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rresp    = rresp_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = prot_q;
  assign m_axil_arvalid = (state_q == ST_AR);
  assign m_axil_rready  = (state_q == ST_WF_R);

endmodule

// File: tb/tb_axi_axil_burst_bridge_rd.sv
// Scoreboard bench for the read burst bridge: one 32/32 instance and one 64/32 instance,
// selected by 'sel', with a behavioural AXI-Lite slave and a decoupled R/AR monitor.
module tb_axi_axil_burst_bridge_rd;

  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } ar_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } lite_t;
  typedef struct packed { logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last; } beat_t;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic        clk, rst_n, sel, lite_hold;
  logic [7:0]  ar_id, ar_len;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size, ar_prot;
  logic [1:0]  ar_burst;
  logic        ar_valid, s_rready;
  logic        m_arready, m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  logic        a_arvalid, a_arready, a_rlast, a_rvalid, a_m_arvalid, a_m_rvalid, a_m_rready;
  logic [7:0]  a_rid;
  logic [31:0] a_rdata, a_m_araddr;
  logic [1:0]  a_rresp;
  logic [2:0]  a_m_arprot;
  logic        b_arvalid, b_arready, b_rlast, b_rvalid, b_m_arvalid, b_m_rvalid, b_m_rready;
  logic [7:0]  b_rid;
  logic [63:0] b_rdata;
  logic [31:0] b_m_araddr;
  logic [1:0]  b_rresp;
  logic [2:0]  b_m_arprot;

  logic        s_arready, r_valid, r_last, ma_valid, ma_rready;
  logic [7:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [31:0] ma_addr;
  logic [2:0]  ma_prot;

  ar_t   exp_ar[$];
  lite_t lite_q[$];
  beat_t exp_r[$];
  int    total = 0;
  int    bad = 0;

  assign a_arvalid  = ar_valid & ~sel;
  assign b_arvalid  = ar_valid & sel;
  assign a_m_rvalid = m_rvalid & ~sel;
  assign b_m_rvalid = m_rvalid & sel;
  assign s_arready  = sel ? b_arready : a_arready;
  assign r_valid    = sel ? b_rvalid : a_rvalid;
  assign r_last     = sel ? b_rlast : a_rlast;
  assign r_id       = sel ? b_rid : a_rid;
  assign r_data     = sel ? b_rdata : {32'd0, a_rdata};
  assign r_resp     = sel ? b_rresp : a_rresp;
  assign ma_valid   = sel ? b_m_arvalid : a_m_arvalid;
  assign ma_rready  = sel ? b_m_rready : a_m_rready;
  assign ma_addr    = sel ? b_m_araddr : a_m_araddr;
  assign ma_prot    = sel ? b_m_arprot : a_m_arprot;

  axi_axil_burst_bridge_rd #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8),
                             .AXIL_DATA_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axi_arid(ar_id), .s_axi_araddr(ar_addr), .s_axi_arlen(ar_len), .s_axi_arsize(ar_size),
    .s_axi_arburst(ar_burst), .s_axi_arprot(ar_prot), .s_axi_arvalid(a_arvalid),
    .s_axi_arready(a_arready), .s_axi_rid(a_rid), .s_axi_rdata(a_rdata), .s_axi_rresp(a_rresp),
    .s_axi_rlast(a_rlast), .s_axi_rvalid(a_rvalid), .s_axi_rready(s_rready),
    .m_axil_araddr(a_m_araddr), .m_axil_arprot(a_m_arprot), .m_axil_arvalid(a_m_arvalid),
    .m_axil_arready(m_arready), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rvalid(a_m_rvalid), .m_axil_rready(a_m_rready)
  );

  axi_axil_burst_bridge_rd #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(8),
                             .AXIL_DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axi_arid(ar_id), .s_axi_araddr(ar_addr), .s_axi_arlen(ar_len), .s_axi_arsize(ar_size),
    .s_axi_arburst(ar_burst), .s_axi_arprot(ar_prot), .s_axi_arvalid(b_arvalid),
    .s_axi_arready(b_arready), .s_axi_rid(b_rid), .s_axi_rdata(b_rdata), .s_axi_rresp(b_rresp),
    .s_axi_rlast(b_rlast), .s_axi_rvalid(b_rvalid), .s_axi_rready(s_rready),
    .m_axil_araddr(b_m_araddr), .m_axil_arprot(b_m_arprot), .m_axil_arvalid(b_m_arvalid),
    .m_axil_arready(m_arready), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rvalid(b_m_rvalid), .m_axil_rready(b_m_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    total++;
    bad++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic expectLite(input logic [31:0] addr, input logic [2:0] prot,
                            input logic [31:0] data, input logic [1:0] resp);
    exp_ar.push_back('{addr: addr, prot: prot});
    lite_q.push_back('{data: data, resp: resp});
  endtask

  task automatic expectBeat(input logic [7:0] id, input logic [63:0] data,
                            input logic [1:0] resp, input logic last);
    exp_r.push_back('{id: id, data: data, resp: resp, last: last});
  endtask

  task automatic applyStimulus(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_prot = prot;
    ar_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_arready) done = 1'b1;
    end
    @(posedge clk); #1;
    ar_valid = 1'b0;
    if (!done) failNow("ar_accept", "got arready=0 for 200 cycles expected 1");
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_r.size() == 0 && exp_ar.size() == 0 && !r_valid && s_arready) done = 1'b1;
    end
    if (!done) begin
      $display("[TB] FAIL drain: got %0d beats and %0d lite reads pending expected 0",
               exp_r.size(), exp_ar.size());
      total++;
      bad++;
      exp_r.delete();
      exp_ar.delete();
      lite_q.delete();
    end
  endtask

  // AXI-Lite slave: zero-wait AR, data returned the cycle after the address handshake.
  initial begin : lite_slave
    lite_t item;
    bit ar_hs, r_hs, pend;
    pend = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    forever begin
      @(negedge clk);
      ar_hs = rst_n && ma_valid && m_arready;
      r_hs  = m_rvalid && ma_rready;
      @(posedge clk); #1;
      if (ar_hs) pend = 1'b1;
      if (r_hs) m_rvalid = 1'b0;
      if (pend && !m_rvalid && !lite_hold) begin
        if (lite_q.size() != 0) begin
          item = lite_q.pop_front();
          m_rdata = item.data;
          m_rresp = item.resp;
        end else begin
          m_rdata = 32'hDEAD_BEEF;
          m_rresp = OKAY;
        end
        m_rvalid = 1'b1;
        pend = 1'b0;
      end
      if (!rst_n) begin
        pend = 1'b0;
        m_rvalid = 1'b0;
      end
    end
  end

  // Monitor: every AXI-Lite AR and every accepted R beat is checked against the queues.
  initial begin : monitor
    ar_t ea;
    beat_t eb;
    bit stalled;
    logic [7:0] h_id;
    logic [63:0] h_data;
    logic [1:0] h_resp;
    logic h_last;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (ma_valid && m_arready) begin
          if (exp_ar.size() == 0) begin
            $display("[TB] FAIL lite_ar: got araddr %h expected no AXI-Lite read", ma_addr);
            total++;
            bad++;
          end else begin
            ea = exp_ar.pop_front();
            checkOutput("lite_araddr", 64'(ma_addr), 64'(ea.addr));
            checkOutput("lite_arprot", 64'(ma_prot), 64'(ea.prot));
          end
        end
        if (r_valid) begin
          if (stalled) begin
            checkOutput("stall_rid", 64'(r_id), 64'(h_id));
            checkOutput("stall_rdata", r_data, h_data);
            checkOutput("stall_rresp", 64'(r_resp), 64'(h_resp));
            checkOutput("stall_rlast", 64'(r_last), 64'(h_last));
          end
          if (s_rready) begin
            stalled = 1'b0;
            if (exp_r.size() == 0) begin
              $display("[TB] FAIL r_beat: got rdata %h expected no beat", r_data);
              total++;
              bad++;
            end else begin
              eb = exp_r.pop_front();
              checkOutput("rid", 64'(r_id), 64'(eb.id));
              checkOutput("rdata", r_data, eb.data);
              checkOutput("rresp", 64'(r_resp), 64'(eb.resp));
              checkOutput("rlast", 64'(r_last), 64'(eb.last));
            end
          end else begin
            stalled = 1'b1;
            h_id = r_id; h_data = r_data; h_resp = r_resp; h_last = r_last;
          end
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    bit seen;
    rst_n = 1'b0; sel = 1'b0; lite_hold = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_prot = '0;
    ar_valid = 1'b0; s_rready = 1'b1; m_arready = 1'b1;

    #1;
    checkOutput("rst_arready_a", 64'(a_arready), 64'd0);
    checkOutput("rst_arready_b", 64'(b_arready), 64'd0);
    checkOutput("rst_rvalid_a", 64'(a_rvalid), 64'd0);
    checkOutput("rst_rlast_a", 64'(a_rlast), 64'd0);
    checkOutput("rst_rdata_a", 64'(a_rdata), 64'd0);
    checkOutput("rst_m_arvalid_a", 64'(a_m_arvalid), 64'd0);
    checkOutput("rst_m_rready_a", 64'(a_m_rready), 64'd0);
    checkOutput("rst_rvalid_b", 64'(b_rvalid), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("arready_after_rst_a", 64'(a_arready), 64'd1);
    checkOutput("arready_after_rst_b", 64'(b_arready), 64'd1);

    $display("[TB] 32/32 INCR len=3 at 0x100");
    expectLite(32'h100, 3'b010, 32'hA0A0_0001, OKAY);
    expectLite(32'h104, 3'b010, 32'hB0B0_0002, OKAY);
    expectLite(32'h108, 3'b010, 32'hC0C0_0003, OKAY);
    expectLite(32'h10C, 3'b010, 32'hD0D0_0004, OKAY);
    expectBeat(8'h5A, 64'hA0A0_0001, OKAY, 1'b0);
    expectBeat(8'h5A, 64'hB0B0_0002, OKAY, 1'b0);
    expectBeat(8'h5A, 64'hC0C0_0003, OKAY, 1'b0);
    expectBeat(8'h5A, 64'hD0D0_0004, OKAY, 1'b1);
    applyStimulus(8'h5A, 32'h100, 8'd3, 3'd2, INCR, 3'b010);
    waitDrain();

    $display("[TB] 32/32 WRAP len=3 at 0x108");
    expectLite(32'h108, 3'b000, 32'h1000_0108, OKAY);
    expectLite(32'h10C, 3'b000, 32'h1000_010C, OKAY);
    expectLite(32'h100, 3'b000, 32'h1000_0100, OKAY);
    expectLite(32'h104, 3'b000, 32'h1000_0104, OKAY);
    expectBeat(8'h21, 64'h1000_0108, OKAY, 1'b0);
    expectBeat(8'h21, 64'h1000_010C, OKAY, 1'b0);
    expectBeat(8'h21, 64'h1000_0100, OKAY, 1'b0);
    expectBeat(8'h21, 64'h1000_0104, OKAY, 1'b1);
    applyStimulus(8'h21, 32'h108, 8'd3, 3'd2, WRAP, 3'b000);
    waitDrain();

    $display("[TB] 32/32 FIXED and unaligned narrow INCR");
    for (int i = 0; i < 3; i++) begin
      expectLite(32'h40, 3'b001, 32'h4000_0000 + 32'(i), OKAY);
      expectBeat(8'h03, 64'h4000_0000 + 64'(i), OKAY, i == 2);
    end
    applyStimulus(8'h03, 32'h40, 8'd2, 3'd2, FIXED, 3'b001);
    waitDrain();
    expectLite(32'h31, 3'b000, 32'h0000_00C1, OKAY);
    expectLite(32'h32, 3'b000, 32'h0000_00C2, OKAY);
    expectLite(32'h34, 3'b000, 32'h0000_00C3, OKAY);
    expectBeat(8'h31, 64'h0000_00C1, OKAY, 1'b0);
    expectBeat(8'h31, 64'h0000_00C2, OKAY, 1'b0);
    expectBeat(8'h31, 64'h0000_00C3, OKAY, 1'b1);
    applyStimulus(8'h31, 32'h31, 8'd2, 3'd1, INCR, 3'b000);
    waitDrain();

    $display("[TB] 32/32 byte WRAP len=15 at 0x203");
    for (int i = 0; i < 16; i++) begin
      expectLite(32'h200 + 32'((3 + i) % 16), 3'b000, 32'hD000_0000 + 32'(i), OKAY);
      expectBeat(8'h16, 64'hD000_0000 + 64'(i), OKAY, i == 15);
    end
    applyStimulus(8'h16, 32'h203, 8'd15, 3'd0, WRAP, 3'b000);
    waitDrain();

    $display("[TB] 32/32 INCR len=255");
    for (int i = 0; i < 256; i++) begin
      expectLite(32'h1000 + 32'(4 * i), 3'b100, 32'h5500_0000 + 32'(i), OKAY);
      expectBeat(8'hFF, 64'h5500_0000 + 64'(i), OKAY, i == 255);
    end
    applyStimulus(8'hFF, 32'h1000, 8'd255, 3'd2, INCR, 3'b100);
    waitDrain();

    $display("[TB] illegal bursts answered locally");
    for (int i = 0; i < 3; i++) expectBeat(8'h44, 64'd0, SLVERR, i == 2);
    applyStimulus(8'h44, 32'h500, 8'd2, 3'd3, INCR, 3'b000);
    waitDrain();
    for (int i = 0; i < 3; i++) expectBeat(8'h45, 64'd0, SLVERR, i == 2);
    applyStimulus(8'h45, 32'h500, 8'd2, 3'd2, WRAP, 3'b000);
    waitDrain();
    expectBeat(8'h46, 64'd0, SLVERR, 1'b1);
    applyStimulus(8'h46, 32'h500, 8'd0, 3'd2, RSVD, 3'b000);
    waitDrain();

    $display("[TB] per-beat SLVERR with R back-pressure");
    expectLite(32'h20, 3'b000, 32'h1111_1111, SLVERR);
    expectLite(32'h24, 3'b000, 32'h2222_2222, OKAY);
    expectBeat(8'h77, 64'h1111_1111, SLVERR, 1'b0);
    expectBeat(8'h77, 64'h2222_2222, OKAY, 1'b1);
    s_rready = 1'b0;
    applyStimulus(8'h77, 32'h20, 8'd1, 3'd2, INCR, 3'b000);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (r_valid) seen = 1'b1;
    end
    if (!seen) failNow("stall_rvalid", "got rvalid=0 for 50 cycles expected 1");
    repeat (5) @(posedge clk);
    #1 s_rready = 1'b1;
    waitDrain();

    $display("[TB] 64/32 lane placement");
    sel = 1'b1;
    expectLite(32'h4, 3'b000, 32'h0000_0011, OKAY);
    expectLite(32'h8, 3'b000, 32'h0000_0022, OKAY);
    expectBeat(8'h64, 64'h0000_0011_0000_0000, OKAY, 1'b0);
    expectBeat(8'h64, 64'h0000_0000_0000_0022, OKAY, 1'b1);
    applyStimulus(8'h64, 32'h4, 8'd1, 3'd2, INCR, 3'b000);
    waitDrain();
    expectLite(32'h0, 3'b000, 32'h0000_0031, OKAY);
    expectLite(32'h4, 3'b000, 32'h0000_0032, OKAY);
    expectLite(32'h8, 3'b000, 32'h0000_0033, OKAY);
    expectLite(32'hC, 3'b000, 32'h0000_0034, OKAY);
    expectBeat(8'h65, 64'h0000_0000_0000_0031, OKAY, 1'b0);
    expectBeat(8'h65, 64'h0000_0032_0000_0000, OKAY, 1'b0);
    expectBeat(8'h65, 64'h0000_0000_0000_0033, OKAY, 1'b0);
    expectBeat(8'h65, 64'h0000_0034_0000_0000, OKAY, 1'b1);
    applyStimulus(8'h65, 32'h0, 8'd3, 3'd2, INCR, 3'b000);
    waitDrain();
    expectBeat(8'h99, 64'd0, SLVERR, 1'b1);
    applyStimulus(8'h99, 32'h0, 8'd0, 3'd3, INCR, 3'b000);
    waitDrain();
    sel = 1'b0;

    $display("[TB] reset while waiting for AXI-Lite data");
    lite_hold = 1'b1;
    expectLite(32'h300, 3'b000, 32'hBAD0_BAD0, OKAY);
    applyStimulus(8'h12, 32'h300, 8'd3, 3'd2, INCR, 3'b000);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ma_rready) seen = 1'b1;
    end
    if (!seen) failNow("wf_r_reached", "got m_axil_rready=0 for 50 cycles expected 1");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_rvalid", 64'(r_valid), 64'd0);
    checkOutput("midrst_m_arvalid", 64'(ma_valid), 64'd0);
    checkOutput("midrst_m_rready", 64'(ma_rready), 64'd0);
    checkOutput("midrst_arready", 64'(s_arready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    lite_q.delete();
    exp_ar.delete();
    exp_r.delete();
    lite_hold = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("arready_after_midrst", 64'(s_arready), 64'd1);
    expectLite(32'h200, 3'b000, 32'hCAFE_F00D, OKAY);
    expectBeat(8'h13, 64'hCAFE_F00D, OKAY, 1'b1);
    applyStimulus(8'h13, 32'h200, 8'd0, 3'd2, INCR, 3'b000);
    waitDrain();

    repeat (3) @(posedge clk);
    checkOutput("lite_leftover", 64'(lite_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
